ctrl_decode_pipe: RTL and testbench

CTRL_DECODE_PIPE -- requirements
Module: ctrl_decode_pipe

---
 rtl/ctrl_pkg.sv | 39 +++
 rtl/ctrl_decode_pipe_if.sv | 48 ++++
 rtl/ctrl_decode_comb.sv | 53 +++++
 rtl/ctrl_decode_pipe.sv | 103 ++++++++++
 tb/tb_ctrl_decode_pipe.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared opcodes, ALU ops, control word and FSM state for the decode pipe
package ctrl_pkg;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_LW  = 4'b1000;
    localparam logic [3:0] OP_SW  = 4'b1010;
    localparam logic [3:0] OP_BNE = 4'b1110;
    localparam logic [3:0] OP_JMP = 4'b1111;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef struct packed {
        logic       reg_dst;
        logic       jump;
        logic       branch;
        logic       mem_read;
        logic       mem2reg;
        logic       mem_write;
        logic       alu_src;
        logic       reg_write;
        logic [2:0] alu_op;
    } ctrl_word_t;

    localparam ctrl_word_t CTRL_NOP = '0;

    typedef enum logic {
        ST_RUN = 1'b0,
        ST_HAZ = 1'b1
    } fsm_state_t;

endpackage

// File: rtl/ctrl_decode_pipe_if.sv
// rtl/ctrl_decode_pipe_if.sv - instruction handshake and control-word bundle (illegal ports under CTRL_ILLEGAL_TRAP_EN)
interface ctrl_decode_pipe_if #(
    parameter int OPW    = 4,
    parameter int RAW    = 3,
    parameter int ALUOPW = 3
) ();
    logic              in_valid;
    logic              in_ready;
    logic [OPW-1:0]    opcode;
    logic [RAW-1:0]    rs;
    logic [RAW-1:0]    rt;
    logic              stall_ext;
    logic              flush;
    logic              out_valid;
    logic              reg_dst;
    logic              jump;
    logic              branch;
    logic              mem_read;
    logic              mem2reg;
    logic              mem_write;
    logic              alu_src;
    logic              reg_write;
    logic [ALUOPW-1:0] alu_op;
    logic [RAW-1:0]    out_rt;
    logic              hazard;
`ifdef CTRL_ILLEGAL_TRAP_EN
    logic              illegal;
    logic              illegal_seen;
`endif

    modport master (
        output in_valid, opcode, rs, rt, stall_ext, flush,
        input  in_ready, out_valid, reg_dst, jump, branch, mem_read, mem2reg,
               mem_write, alu_src, reg_write, alu_op, out_rt, hazard
`ifdef CTRL_ILLEGAL_TRAP_EN
        , input illegal, illegal_seen
`endif
    );

    modport slave (
        input  in_valid, opcode, rs, rt, stall_ext, flush,
        output in_ready, out_valid, reg_dst, jump, branch, mem_read, mem2reg,
               mem_write, alu_src, reg_write, alu_op, out_rt, hazard
`ifdef CTRL_ILLEGAL_TRAP_EN
        , output illegal, illegal_seen
`endif
    );
endinterface

// File: rtl/ctrl_decode_comb.sv
// rtl/ctrl_decode_comb.sv - opcode to control word decode (illegal flag under CTRL_ILLEGAL_TRAP_EN)
module ctrl_decode_comb
    import ctrl_pkg::*;
#(
    parameter int OPW = 4
) (
    input  logic [OPW-1:0] i_opcode,
    output ctrl_word_t     o_ctrl
`ifdef CTRL_ILLEGAL_TRAP_EN
    ,
    output logic           o_illegal
`endif
);

    logic w_hi_zero;
    logic w_unlisted;

    // Opcode bits above [3] must be zero for any listed opcode to match
    generate
        if (OPW > 4) begin : g_wide
            assign w_hi_zero = ~|i_opcode[OPW-1:4];
        end else begin : g_narrow
            assign w_hi_zero = 1'b1;
        end
    endgenerate

    // Table decode; anything not listed falls through to an all-zero NOP
    always_comb begin
        o_ctrl     = CTRL_NOP;
        w_unlisted = 1'b0;
        if (w_hi_zero) begin
            case (i_opcode[3:0])
                OP_AND: o_ctrl = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ALU_AND};
                OP_OR:  o_ctrl = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ALU_OR};
                OP_ADD: o_ctrl = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ALU_ADD};
                OP_SUB: o_ctrl = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ALU_SUB};
                OP_SLT: o_ctrl = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ALU_SLT};
                OP_LW:  o_ctrl = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, ALU_ADD};
                OP_SW:  o_ctrl = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, ALU_ADD};
                OP_BNE: o_ctrl = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ALU_ADD};
                OP_JMP: o_ctrl = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ALU_ADD};
                default: w_unlisted = 1'b1;
            endcase
        end else begin
            w_unlisted = 1'b1;
        end
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    assign o_illegal = w_unlisted;
`endif

endmodule

// File: rtl/ctrl_decode_pipe.sv
// rtl/ctrl_decode_pipe.sv - one-stage decode pipe with load-use bubble, stall and flush; optional CTRL_ILLEGAL_TRAP_EN
module ctrl_decode_pipe
    import ctrl_pkg::*;
#(
    parameter int OPW    = 4,
    parameter int RAW    = 3,
    parameter int ALUOPW = 3
) (
    input logic               clock,
    input logic               reset,
    ctrl_decode_pipe_if.slave bus
);

    fsm_state_t     r_state;
    logic           r_valid;
    ctrl_word_t     r_ctrl;
    logic [RAW-1:0] r_rt;
    ctrl_word_t     w_dec;
    logic           w_rt_match;
    logic           w_hazard_cond;
    logic           w_hazard;
    logic           w_in_ready;
`ifdef CTRL_ILLEGAL_TRAP_EN
    logic           w_dec_illegal;
    logic           r_illegal;
    logic           r_illegal_seen;
`endif

    ctrl_decode_comb #(.OPW(OPW)) u_decode (
        .i_opcode  (bus.opcode),
        .o_ctrl    (w_dec)
`ifdef CTRL_ILLEGAL_TRAP_EN
        ,
        .o_illegal (w_dec_illegal)
`endif
    );

    // Load-use check: a load in the output stage writes a register the offered instruction reads
    assign w_rt_match    = (r_rt == bus.rs) || (r_rt == bus.rt);
    assign w_hazard_cond = (r_state == ST_RUN) && r_valid && r_ctrl.mem_read && w_rt_match && bus.in_valid;

    // Flush always consumes; otherwise stall and hazard both block acceptance
    assign w_hazard   = !reset && !bus.flush && !bus.stall_ext && w_hazard_cond;
    assign w_in_ready = !reset && (bus.flush || (!bus.stall_ext && !w_hazard_cond));

    // Output stage and FSM: reset > flush > stall > bubble > accept
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_RUN;
            r_valid <= 1'b0;
            r_ctrl  <= CTRL_NOP;
            r_rt    <= '0;
`ifdef CTRL_ILLEGAL_TRAP_EN
            r_illegal      <= 1'b0;
            r_illegal_seen <= 1'b0;
`endif
        end else if (bus.flush) begin
            r_state <= ST_RUN;
            r_valid <= 1'b0;
            r_ctrl  <= CTRL_NOP;
`ifdef CTRL_ILLEGAL_TRAP_EN
            r_illegal <= 1'b0;
`endif
        end else if (bus.stall_ext) begin
            r_state <= r_state;
        end else if (w_hazard_cond) begin
            r_state <= ST_HAZ;
            r_valid <= 1'b0;
            r_ctrl  <= CTRL_NOP;
`ifdef CTRL_ILLEGAL_TRAP_EN
            r_illegal <= 1'b0;
`endif
        end else begin
            r_state <= ST_RUN;
            r_valid <= bus.in_valid;
            r_ctrl  <= bus.in_valid ? w_dec : CTRL_NOP;
            r_rt    <= bus.rt;
`ifdef CTRL_ILLEGAL_TRAP_EN
            r_illegal      <= bus.in_valid && w_dec_illegal;
            r_illegal_seen <= r_illegal_seen || (bus.in_valid && w_dec_illegal);
`endif
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.hazard    = w_hazard;
    assign bus.out_valid = r_valid;
    assign bus.reg_dst   = r_ctrl.reg_dst;
    assign bus.jump      = r_ctrl.jump;
    assign bus.branch    = r_ctrl.branch;
    assign bus.mem_read  = r_ctrl.mem_read;
    assign bus.mem2reg   = r_ctrl.mem2reg;
    assign bus.mem_write = r_ctrl.mem_write;
    assign bus.alu_src   = r_ctrl.alu_src;
    assign bus.reg_write = r_ctrl.reg_write;
    assign bus.alu_op    = ALUOPW'(r_ctrl.alu_op);
    assign bus.out_rt    = r_rt;
`ifdef CTRL_ILLEGAL_TRAP_EN
    assign bus.illegal      = r_illegal;
    assign bus.illegal_seen = r_illegal_seen;
`endif

endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// tb/tb_ctrl_decode_pipe.sv - scoreboard bench for ctrl_decode_pipe (CTRL_ILLEGAL_TRAP_EN aware)
module tb_ctrl_decode_pipe;

`ifdef CTRL_ILLEGAL_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic clk;
    logic reset;
    logic fresh;
    int   tests;
    int   fails;
    logic [14:0] sb[$];

    ctrl_decode_pipe_if #(.OPW(4), .RAW(3), .ALUOPW(3)) bus ();

    ctrl_decode_pipe #(.OPW(4), .RAW(3), .ALUOPW(3)) dut (
        .clock (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", nm, got, exp);
        end
    endtask

    // Hand-written decode table: {illegal, 8 control bits, alu_op, rt}
    function automatic logic [14:0] mk(input logic [3:0] op, input logic [2:0] t);
        logic [10:0] c;
        logic        ill;
        ill = 1'b0;
        case (op)
            4'b0000: c = 11'b1000_0001_000;
            4'b0001: c = 11'b1000_0001_001;
            4'b0010: c = 11'b1000_0001_010;
            4'b0110: c = 11'b1000_0001_110;
            4'b0111: c = 11'b1000_0001_111;
            4'b1000: c = 11'b1001_1011_010;
            4'b1010: c = 11'b1000_0110_010;
            4'b1110: c = 11'b0010_0000_010;
            4'b1111: c = 11'b0100_0000_010;
            default: begin c = '0; ill = 1'b1; end
        endcase
        return {ill & TRAP_EN, c, t};
    endfunction

    function automatic logic [14:0] got_word();
        logic ill;
`ifdef CTRL_ILLEGAL_TRAP_EN
        ill = bus.illegal;
`else
        ill = 1'b0;
`endif
        return {ill, bus.reg_dst, bus.jump, bus.branch, bus.mem_read, bus.mem2reg,
                bus.mem_write, bus.alu_src, bus.reg_write, bus.alu_op, bus.out_rt};
    endfunction

    // An edge produces a new output word only when not in reset and not stalled
    always @(posedge clk) fresh <= !reset && (bus.flush || !bus.stall_ext);

    // Monitor: pop one expected word per new valid output, bubbles must be all-zero
    initial begin
        logic [14:0] g;
        logic [14:0] e;
        forever begin
            @(negedge clk);
            if (fresh === 1'b1) begin
                g = got_word();
                if (bus.out_valid) begin
                    if (sb.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_output: got %0h, required no output", g);
                    end else begin
                        e = sb.pop_front();
                        check("out_word", 32'(g), 32'(e));
                    end
                end else begin
                    check("bubble_ctrl", 32'(g[14:3]), 32'd0);
                end
            end
        end
    end

    task automatic drive(input logic v, input logic [3:0] op, input logic [2:0] s, input logic [2:0] t,
                         input logic st, input logic fl, input logic exp_rdy, input logic exp_hz,
                         input string nm);
        @(negedge clk);
        bus.in_valid  = v;
        bus.opcode    = op;
        bus.rs        = s;
        bus.rt        = t;
        bus.stall_ext = st;
        bus.flush     = fl;
        #1;
        check({nm, "_in_ready"}, 32'(bus.in_ready), 32'(exp_rdy));
        check({nm, "_hazard"}, 32'(bus.hazard), 32'(exp_hz));
        if (v && exp_rdy && !fl) sb.push_back(mk(op, t));
    endtask

    task automatic idle(input string nm);
        drive(1'b0, 4'b0000, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, nm);
    endtask

    initial begin
        tests         = 0;
        fails         = 0;
        fresh         = 1'b0;
        reset         = 1'b1;
        bus.in_valid  = 1'b1;
        bus.opcode    = 4'b0010;
        bus.rs        = 3'd0;
        bus.rt        = 3'd1;
        bus.stall_ext = 1'b0;
        bus.flush     = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_alu_op", 32'(bus.alu_op), 32'd0);
        check("rst_out_rt", 32'(bus.out_rt), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_hazard", 32'(bus.hazard), 32'd0);
        bus.in_valid = 1'b0;
        reset        = 1'b0;

        // ADD straight after reset
        drive(1, 4'b0010, 3'd1, 3'd2, 0, 0, 1, 0, "add");
        idle("idle1");

        // load-use on rs: hazard cycle, bubble, then ADD
        drive(1, 4'b1000, 3'd0, 3'd3, 0, 0, 1, 0, "lw1");
        drive(1, 4'b0010, 3'd3, 3'd0, 0, 0, 0, 1, "haz1");
        drive(1, 4'b0010, 3'd3, 3'd0, 0, 0, 1, 0, "haz1_acc");
        check("bubble_after_haz", 32'(bus.out_valid), 32'd0);

        // no register match: back-to-back
        drive(1, 4'b1000, 3'd0, 3'd3, 0, 0, 1, 0, "lw2");
        drive(1, 4'b0010, 3'd2, 3'd4, 0, 0, 1, 0, "nohaz");
        drive(1, 4'b0000, 3'd0, 3'd1, 0, 0, 1, 0, "and");

        // load-use on rt
        drive(1, 4'b1000, 3'd5, 3'd4, 0, 0, 1, 0, "lw3");
        drive(1, 4'b1010, 3'd0, 3'd4, 0, 0, 0, 1, "haz_rt");
        drive(1, 4'b1010, 3'd0, 3'd4, 0, 0, 1, 0, "sw_acc");

        // remaining opcodes
        drive(1, 4'b0001, 3'd1, 3'd2, 0, 0, 1, 0, "or");
        drive(1, 4'b0111, 3'd2, 3'd3, 0, 0, 1, 0, "slt");
        drive(1, 4'b1110, 3'd3, 3'd4, 0, 0, 1, 0, "bne");
        drive(1, 4'b1111, 3'd4, 3'd5, 0, 0, 1, 0, "jmp");

        // external stall holds SUB for 3 cycles
        drive(1, 4'b0110, 3'd0, 3'd5, 0, 0, 1, 0, "sub");
        for (int i = 0; i < 3; i++) begin
            drive(1, 4'b0001, 3'd0, 3'd1, 1, 0, 0, 0, "stall");
            check("stall_out_valid", 32'(bus.out_valid), 32'd1);
            check("stall_alu_op", 32'(bus.alu_op), 32'h6);
        end
        drive(1, 4'b0001, 3'd0, 3'd1, 0, 0, 1, 0, "or_after_stall");
        idle("idle2");

        // flush during HAZ discards JMP and returns to RUN
        drive(1, 4'b1000, 3'd0, 3'd6, 0, 0, 1, 0, "lw4");
        drive(1, 4'b0010, 3'd6, 3'd0, 0, 0, 0, 1, "haz2");
        drive(1, 4'b1111, 3'd0, 3'd0, 0, 1, 1, 0, "flush_haz");
        idle("idle3");
        check("flush_out_valid", 32'(bus.out_valid), 32'd0);
        drive(1, 4'b1000, 3'd0, 3'd1, 0, 0, 1, 0, "lw5");
        drive(1, 4'b0010, 3'd1, 3'd0, 0, 0, 0, 1, "haz_after_flush");
        drive(1, 4'b0010, 3'd1, 3'd0, 0, 0, 1, 0, "add_after_flush");

        // flush outranks a pending hazard in RUN
        drive(1, 4'b1000, 3'd0, 3'd2, 0, 0, 1, 0, "lw6");
        drive(1, 4'b0010, 3'd2, 3'd0, 0, 1, 1, 0, "flush_pri");
        idle("idle4");

        // unlisted opcodes
        drive(1, 4'b0011, 3'd0, 3'd5, 0, 0, 1, 0, "op0011");
        drive(1, 4'b0100, 3'd1, 3'd6, 0, 0, 1, 0, "op0100");
`ifdef CTRL_ILLEGAL_TRAP_EN
        check("illegal_flag", 32'(bus.illegal), 32'd1);
        check("illegal_seen_set", 32'(bus.illegal_seen), 32'd1);
`endif
        drive(1, 4'b0010, 3'd0, 3'd0, 0, 0, 1, 0, "add_after_ill");
        idle("idle5");
`ifdef CTRL_ILLEGAL_TRAP_EN
        check("illegal_clear", 32'(bus.illegal), 32'd0);
        check("illegal_seen_sticky", 32'(bus.illegal_seen), 32'd1);
`endif

        // reset in the middle of a hazard
        drive(1, 4'b1000, 3'd0, 3'd2, 0, 0, 1, 0, "lw7");
        drive(1, 4'b0010, 3'd2, 3'd0, 0, 0, 0, 1, "haz3");
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        #1;
        check("rst_haz_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_haz_hazard", 32'(bus.hazard), 32'd0);
        @(negedge clk);
        #1;
        check("rst_haz_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_haz_mem_read", 32'(bus.mem_read), 32'd0);
        check("rst_haz_out_rt", 32'(bus.out_rt), 32'd0);
`ifdef CTRL_ILLEGAL_TRAP_EN
        check("rst_illegal_seen", 32'(bus.illegal_seen), 32'd0);
`endif
        reset = 1'b0;
        drive(1, 4'b0010, 3'd2, 3'd0, 0, 0, 1, 0, "post_rst");
        idle("idle6");
        idle("idle7");

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
